// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared 128-word data memory between fetch and load/store requesters.
// One access per IDLE->ACCESS->RESP pass; rejected accesses skip the memory cycle.
module mem_port_arbiter #(
   parameter int          ADDR_W       = 64,
   parameter int          DATA_W       = 64,
   parameter int unsigned MAX_ADDR     = 1016,
   parameter int          STARVE_LIMIT = 4
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              f_req_i,
   input  logic [ADDR_W-1:0] f_addr_i,
   output logic              f_ack_o,
   output logic [DATA_W-1:0] f_data_o,
   output logic              f_err_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic              d_ack_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_err_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic              mem_read_o,
   output logic              mem_write_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              busy_o,
   output logic              fault_o
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic              we;
      logic              own_d;
      logic              err;
   } req_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_e            state_q, state_d;
   req_t              req_q, req_d;
   logic [3:0]        starve_q, starve_d;
   logic              fault_q, fault_d;
   logic [DATA_W-1:0] f_data_q, f_data_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              gnt_d;

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         state_q   <= IDLE;
         req_q     <= '0;
         starve_q  <= '0;
         fault_q   <= 1'b0;
         f_data_q  <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         starve_q  <= starve_d;
         fault_q   <= fault_d;
         f_data_q  <= f_data_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      starve_d  = starve_q;
      fault_d   = fault_q;
      f_data_d  = f_data_q;
      d_rdata_d = d_rdata_q;
      gnt_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!f_req_i)
               starve_d = '0;
            if (f_req_i || d_req_i) begin
               // Data wins unless fetch has already been passed over LIMIT times.
               gnt_d       = d_req_i && !(f_req_i && starve_q == LIMIT);
               req_d.own_d = gnt_d;
               req_d.addr  = gnt_d ? d_addr_i : f_addr_i;
               req_d.we    = gnt_d && d_we_i;
               if (gnt_d)
                  req_d.wdata = d_wdata_i;
               req_d.err = (req_d.addr > ADDR_W'(MAX_ADDR)) || (req_d.addr[2:0] != 3'b000);
               if (!gnt_d)
                  starve_d = '0;
               else if (f_req_i && starve_q != LIMIT)
                  starve_d = starve_q + 4'd1;
               if (req_d.err) begin
                  state_d = RESP;
                  fault_d = 1'b1;
                  if (gnt_d)
                     d_rdata_d = '0;
                  else
                     f_data_d = '0;
               end else begin
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            state_d = RESP;
            if (req_q.own_d)
               d_rdata_d = req_q.we ? '0 : mem_rdata_i;
            else
               f_data_d = mem_rdata_i;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Enables and acks decode the state register so a cycle in flight finishes under reset.
   assign busy_o      = (state_q != IDLE);
   assign mem_read_o  = (state_q == ACCESS) && !req_q.we;
   assign mem_write_o = (state_q == ACCESS) && req_q.we;
   assign mem_addr_o  = req_q.addr;
   assign mem_wdata_o = req_q.wdata;
   assign f_ack_o     = (state_q == RESP) && !req_q.own_d;
   assign d_ack_o     = (state_q == RESP) && req_q.own_d;
   assign f_err_o     = f_ack_o && req_q.err;
   assign d_err_o     = d_ack_o && req_q.err;
   assign f_data_o    = f_data_q;
   assign d_rdata_o   = d_rdata_q;
   assign fault_o     = fault_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-timeline model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;
   localparam int LIM = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [63:0] f_addr = '0, d_addr = '0, d_wdata = '0;
   logic        f_ack, f_err, d_ack, d_err, mem_read, mem_write, busy, fault;
   logic [63:0] f_data, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        preload = 1'b1;
   logic [63:0] env_mem [128];
   int          checks = 0, failures = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_ADDR(1016), .STARVE_LIMIT(LIM)) dut (
      .clock_i(clk), .reset_i(rst_n),
      .f_req_i(f_req), .f_addr_i(f_addr), .f_ack_o(f_ack), .f_data_o(f_data), .f_err_o(f_err),
      .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
      .d_ack_o(d_ack), .d_rdata_o(d_rdata), .d_err_o(d_err),
      .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_read_o(mem_read),
      .mem_write_o(mem_write), .mem_rdata_i(mem_rdata), .busy_o(busy), .fault_o(fault));

   // Environment memory: word i preloads to 0xA9+i, so word 2 holds 0xAB.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 128; i++) env_mem[i] <= 64'hA9 + 64'(i);
      end else if (mem_write) begin
         env_mem[mem_addr[9:3]] <= mem_wdata;
      end
   end
   assign mem_rdata = env_mem[mem_addr[9:3]];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Model: each grant at edge g puts a memory cycle at g and the ack at g+1
   // (or just the ack at g when rejected); the next grant may come at ack+2.
   int          cyc = 0, m_gnt = -10, m_mem = -10, m_ack = -10, m_n = 0;
   logic        m_own_d = 0, m_we = 0, m_err = 0, m_fault = 0, wd;
   logic [63:0] m_addr = 0, m_wdata = 0, m_fd = 0, m_drd = 0;
   logic [63:0] mmem [128];
   bit          cmp_en = 0;

   always @(posedge clk) begin
      cyc++;
      if (preload) for (int i = 0; i < 128; i++) mmem[i] = 64'hA9 + 64'(i);
      if (cyc == m_mem + 1) begin
         if (m_we) begin
            mmem[m_addr[9:3]] = m_wdata;
            m_drd = 0;
         end else if (m_own_d) m_drd = mmem[m_addr[9:3]];
         else m_fd = mmem[m_addr[9:3]];
      end
      if (!rst_n) begin
         m_gnt = -10; m_mem = -10; m_ack = -10; m_n = 0;
         m_own_d = 0; m_we = 0; m_err = 0; m_fault = 0;
         m_addr = 0; m_wdata = 0; m_fd = 0; m_drd = 0;
         cmp_en = 1;
      end else if (cyc >= m_ack + 2) begin
         if (!f_req) m_n = 0;
         if (f_req || d_req) begin
            wd = d_req && !(f_req && m_n == LIM);
            m_own_d = wd;
            m_addr = wd ? d_addr : f_addr;
            m_we = wd && d_we;
            if (wd) m_wdata = d_wdata;
            if (!wd) m_n = 0;
            else if (f_req) m_n = (m_n < LIM) ? m_n + 1 : LIM;
            m_err = (m_addr > 64'd1016) || (m_addr % 8 != 0);
            m_gnt = cyc;
            if (m_err) begin
               m_mem = -10; m_ack = cyc; m_fault = 1;
               if (wd) m_drd = 0; else m_fd = 0;
            end else begin
               m_mem = cyc; m_ack = cyc + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("busy", busy, 64'(cyc >= m_gnt && cyc <= m_ack));
         chk("mem_read", mem_read, 64'(cyc == m_mem && !m_we));
         chk("mem_write", mem_write, 64'(cyc == m_mem && m_we));
         chk("mem_addr", mem_addr, m_addr);
         if (cyc == m_mem && m_we) chk("mem_wdata", mem_wdata, m_wdata);
         chk("f_ack", f_ack, 64'(cyc == m_ack && !m_own_d));
         chk("d_ack", d_ack, 64'(cyc == m_ack && m_own_d));
         if (cyc == m_ack && !m_own_d) chk("f_err", f_err, 64'(m_err));
         if (cyc == m_ack && m_own_d) chk("d_err", d_err, 64'(m_err));
         chk("f_data", f_data, m_fd);
         chk("d_rdata", d_rdata, m_drd);
         chk("fault", fault, 64'(m_fault));
      end
   end

   task automatic access(input bit isd, input logic we, input logic [63:0] a, input logic [63:0] wdat,
                         output logic err, output logic [63:0] rd, output int ack_c,
                         output int rd_c, output int wr_n, output logic [63:0] wr_a);
      @(posedge clk); #1;
      if (isd) begin
         d_req = 1; d_we = we; d_addr = a; d_wdata = wdat;
      end else begin
         f_req = 1; f_addr = a;
      end
      ack_c = -1; rd_c = -1; wr_n = 0; err = 0; rd = 0; wr_a = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (mem_read && rd_c < 0) rd_c = i;
         if (mem_write) begin wr_n++; wr_a = mem_addr; end
         if (isd ? d_ack : f_ack) begin
            ack_c = i; err = isd ? d_err : f_err; rd = isd ? d_rdata : f_data;
            break;
         end
      end
      @(posedge clk); #1;
      if (isd) d_req = 0; else f_req = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic        err;
      logic [63:0] rd, wa;
      int          ac, rc, wn, n, acks;
      logic [9:0]  seq;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_fault", fault, 0);
      chk("rst_mem_read", mem_read, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_d_ack", d_ack, 0);
      @(posedge clk); #1; rst_n = 1; preload = 0;

      access(1, 0, 64'h10, 0, err, rd, ac, rc, wn, wa);
      chk("load_rdata", rd, 64'hAB);
      chk("load_ack_cycle", 64'(ac), 3);
      chk("load_read_cycle", 64'(rc), 2);
      chk("load_err", err, 0);

      access(1, 1, 64'h3F8, 64'h55, err, rd, ac, rc, wn, wa);
      chk("store_writes", 64'(wn), 1);
      chk("store_addr", wa, 64'h3F8);
      chk("store_err", err, 0);
      chk("store_ack_cycle", 64'(ac), 3);
      chk("store_mem", env_mem[127], 64'h55);

      access(1, 0, 64'h3F8, 0, err, rd, ac, rc, wn, wa);
      chk("loadback", rd, 64'h55);
      access(0, 0, 64'h8, 0, err, rd, ac, rc, wn, wa);
      chk("fetch_data", rd, 64'hAA);
      chk("fetch_ack_cycle", 64'(ac), 3);

      // Both requesters held: expect D,D,D,D,F twice.
      @(posedge clk); #1;
      f_req = 1; f_addr = 64'h8; d_req = 1; d_we = 0; d_addr = 64'h18;
      n = 0; seq = '0;
      for (int i = 0; i < 100 && n < 10; i++) begin
         @(negedge clk);
         if (d_ack) begin seq[9-n] = 1'b1; n++; end
         else if (f_ack) begin seq[9-n] = 1'b0; n++; end
      end
      chk("starve_count", 64'(n), 10);
      chk("starve_seq", 64'(seq), 64'(10'b1111011110));
      @(posedge clk); #1; f_req = 0; d_req = 0;

      access(1, 0, 64'h3, 0, err, rd, ac, rc, wn, wa);
      chk("derr_err", err, 1);
      chk("derr_noread", 64'(rc < 0), 1);
      chk("derr_nowrite", 64'(wn), 0);
      chk("derr_ack_cycle", 64'(ac), 2);
      chk("derr_fault", fault, 1);
      access(0, 0, 64'h400, 0, err, rd, ac, rc, wn, wa);
      chk("ferr_err", err, 1);
      chk("ferr_noread", 64'(rc < 0), 1);
      chk("ferr_data", rd, 0);
      chk("ferr_fault", fault, 1);

      // Reset asserted while a store's memory cycle is on the port.
      @(posedge clk); #1;
      d_req = 1; d_we = 1; d_addr = 64'h20; d_wdata = 64'h77;
      wn = 0; acks = 0; n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (d_ack) acks++;
         if (mem_write) begin wn++; rst_n = 0; d_req = 0; n = 1; break; end
      end
      chk("rstacc_write_seen", 64'(n), 1);
      @(posedge clk); #1; rst_n = 1;
      @(negedge clk);
      chk("rstacc_busy", busy, 0);
      chk("rstacc_rdata", d_rdata, 0);
      chk("rstacc_fault", fault, 0);
      chk("rstacc_mem_addr", mem_addr, 0);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         if (mem_write) wn++;
         if (d_ack) acks++;
      end
      chk("rstacc_writes", 64'(wn), 1);
      chk("rstacc_acks", 64'(acks), 0);
      chk("rstacc_mem", env_mem[4], 64'h77);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
